// File: rtl/led_bar_decoder.sv
// Bar-graph LED animation monitor: window-accumulates the bar, decodes fill level, tracks fill/drain sequence.
// Optional stall detector enabled by defining LBD_STALL_DET_EN.
module led_bar_decoder #(
  parameter int unsigned WIN       = 16,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned STALL_WIN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       bar_in,
  output logic [3:0]       level,
  output logic             level_vld,
  output logic             dir,
  output logic             lock,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycles
);

  localparam int unsigned WCW = (WIN > 1) ? $clog2(WIN) : 1;

  typedef enum logic [1:0] {IDLE, ACQ, RISE, FALL} state_t;

  state_t           state_q, state_nxt;
  logic [WCW-1:0]   wcnt_q;
  logic [7:0]       acc_q;
  logic             prev_vld_q, prev_vld_nxt;
  logic [3:0]       level_nxt;
  logic             vld_nxt, err_nxt, lock_nxt, dir_nxt;
  logic [1:0]       code_nxt;
  logic [CNT_W-1:0] cycles_nxt;

  logic [7:0]       snap_c;
  logic             win_end_c, thermo_c, hold_c;
  logic [3:0]       k_c;

`ifdef LBD_STALL_DET_EN
  localparam int unsigned SCW = $clog2(STALL_WIN + 1);
  logic [SCW-1:0]   stall_q, stall_nxt;
`endif

  // Window contents as seen on the window-end cycle, and its decode
  always_comb begin
    snap_c    = acc_q | bar_in;
    win_end_c = en && (wcnt_q == WCW'(WIN - 1));
    thermo_c  = ((snap_c & (snap_c + 8'd1)) == 8'd0);
    k_c       = 4'd0;
    for (int i = 0; i < 8; i++) k_c = k_c + {3'b000, snap_c[i]};
  end

  // Sequence tracker; prev level is the registered level, qualified by prev_vld
  always_comb begin
    state_nxt    = state_q;
    prev_vld_nxt = prev_vld_q;
    level_nxt    = level;
    vld_nxt      = 1'b0;
    err_nxt      = 1'b0;
    code_nxt     = err_code;
    cycles_nxt   = cycles;
    hold_c       = 1'b0;
    if (!en) begin
      state_nxt    = IDLE;
      prev_vld_nxt = 1'b0;
    end else begin
      if (state_q == IDLE) state_nxt = ACQ;
      if (win_end_c) begin
        if (!thermo_c) begin
          err_nxt  = 1'b1;
          code_nxt = 2'b01;
        end else begin
          vld_nxt      = 1'b1;
          level_nxt    = k_c;
          prev_vld_nxt = 1'b1;
          case (state_q)
            ACQ: begin
              if (!prev_vld_q)                 state_nxt = ACQ;
              else if (k_c == 4'd8)            state_nxt = FALL;
              else if (k_c == 4'd0)            state_nxt = RISE;
              else if (k_c == level + 4'd1)    state_nxt = RISE;
              else if (k_c + 4'd1 == level)    state_nxt = FALL;
              else if (k_c != level) begin
                err_nxt  = 1'b1;
                code_nxt = 2'b10;
              end
            end
            RISE: begin
              if (k_c == level)                hold_c = 1'b1;
              else if (k_c == level + 4'd1)    state_nxt = (k_c == 4'd8) ? FALL : RISE;
              else begin
                err_nxt   = 1'b1;
                code_nxt  = 2'b10;
                state_nxt = ACQ;
              end
            end
            FALL: begin
              if (k_c == level)                hold_c = 1'b1;
              else if (k_c + 4'd1 == level) begin
                if (k_c == 4'd0) begin
                  state_nxt = RISE;
                  if (cycles != {CNT_W{1'b1}}) cycles_nxt = cycles + CNT_W'(1);
                end
              end else begin
                err_nxt   = 1'b1;
                code_nxt  = 2'b10;
                state_nxt = ACQ;
              end
            end
            default: state_nxt = ACQ;
          endcase
        end
      end
    end

`ifdef LBD_STALL_DET_EN
    stall_nxt = stall_q;
    if (hold_c) begin
      if (stall_q + SCW'(1) == SCW'(STALL_WIN)) begin
        err_nxt   = 1'b1;
        code_nxt  = 2'b11;
        state_nxt = ACQ;
        stall_nxt = '0;
      end else begin
        stall_nxt = stall_q + SCW'(1);
      end
    end else if (vld_nxt) begin
      stall_nxt = '0;
    end
    if (state_nxt != RISE && state_nxt != FALL) stall_nxt = '0;
`endif

    lock_nxt = (state_nxt == RISE) || (state_nxt == FALL);
    dir_nxt  = (state_nxt == RISE);
  end

  // State, window and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      acc_q      <= '0;
      prev_vld_q <= 1'b0;
      level      <= '0;
      level_vld  <= 1'b0;
      dir        <= 1'b0;
      lock       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      cycles     <= '0;
`ifdef LBD_STALL_DET_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_nxt;
      prev_vld_q <= prev_vld_nxt;
      level      <= level_nxt;
      level_vld  <= vld_nxt;
      dir        <= dir_nxt;
      lock       <= lock_nxt;
      err        <= err_nxt;
      err_code   <= code_nxt;
      cycles     <= cycles_nxt;
`ifdef LBD_STALL_DET_EN
      stall_q    <= stall_nxt;
`endif
      if (!en || win_end_c) begin
        wcnt_q <= '0;
        acc_q  <= '0;
      end else begin
        wcnt_q <= wcnt_q + WCW'(1);
        acc_q  <= snap_c;
      end
    end
  end

endmodule

// File: tb/tb_led_bar_decoder.sv
// Directed bench for led_bar_decoder with WIN=4, CNT_W=2, STALL_WIN=3.
module tb_led_bar_decoder;

  localparam int unsigned WIN   = 4;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [7:0]       bar_in;
  logic [3:0]       level;
  logic             level_vld, dir, lock, err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycles;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  flick    = 1'b0;
  int  exp_code = 0;
  int  exp_cycles = 0;

  logic [7:0] pats [17] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                            8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h01};
  int         lvls [17] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1};

  led_bar_decoder #(.WIN(WIN), .CNT_W(CNT_W), .STALL_WIN(3)) dut (
    .clk(clk), .rst(rst), .en(en), .bar_in(bar_in),
    .level(level), .level_vld(level_vld), .dir(dir), .lock(lock),
    .err(err), .err_code(err_code), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full window, then check outputs on the cycle after its end
  task automatic wchk(input string tag, input logic [7:0] pat, input int lv, input bit vld,
                      input bit er, input bit lk, input bit dr);
    for (int i = 0; i < int'(WIN); i++) begin
      bar_in = (flick && (i % 2 == 1)) ? 8'h00 : pat;
      tick();
    end
    check({tag, ".level"},    32'(level),     32'(lv));
    check({tag, ".vld"},      32'(level_vld), 32'(vld));
    check({tag, ".err"},      32'(err),       32'(er));
    check({tag, ".lock"},     32'(lock),      32'(lk));
    check({tag, ".dir"},      32'(dir),       32'(dr));
    check({tag, ".code"},     32'(err_code),  32'(exp_code));
    check({tag, ".cycles"},   32'(cycles),    32'(exp_cycles));
  endtask

  // Walk the pattern table; acq marks a pass starting from an unlocked tracker
  task automatic sweep(input int from, input int to, input int reps, input bit acq);
    for (int i = from; i <= to; i++) begin
      for (int r = 0; r < reps; r++) begin
        if (i == 15 && r == 0 && exp_cycles < 3) exp_cycles++;
        wchk($sformatf("sweep%0d_%0d", i, r), pats[i], lvls[i], 1'b1, 1'b0,
             !(acq && i == 0), ((i <= 6) && !(acq && i == 0)) || i >= 15);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; bar_in = 8'h00;
    repeat (3) tick();
    check("rst.level", 32'(level), 0);
    check("rst.vld",   32'(level_vld), 0);
    check("rst.dir",   32'(dir), 0);
    check("rst.lock",  32'(lock), 0);
    check("rst.err",   32'(err), 0);
    check("rst.code",  32'(err_code), 0);
    check("rst.cycles", 32'(cycles), 0);
    rst = 1'b1;
    tick();

    // First window, steady bar
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bar_in = 8'h01;
      tick();
      check($sformatf("first.novld%0d", i), 32'(level_vld), 0);
    end
    tick();
    check("first.vld",   32'(level_vld), 1);
    check("first.level", 32'(level), 1);
    check("first.lock",  32'(lock), 0);
    check("first.err",   32'(err), 0);

    // Full fill/drain sweep with flicker
    flick = 1'b1;
    sweep(0, 16, 2, 1'b1);

    // Non-thermometer and jump from RISE at level 3
    wchk("r2", 8'h03, 2, 1'b1, 1'b0, 1'b1, 1'b1);
    wchk("r3", 8'h07, 3, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_code = 1;
    wchk("nontherm", 8'h0B, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    exp_code = 2;
    wchk("jump", 8'h3F, 6, 1'b1, 1'b1, 1'b0, 1'b0);
    wchk("reacq7", 8'h7F, 7, 1'b1, 1'b0, 1'b1, 1'b1);

    // Drop enable mid-window
    bar_in = 8'h01;
    tick();
    tick();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bar_in = 8'hFF;
      tick();
      check($sformatf("enlo%0d.vld", i),  32'(level_vld), 0);
      check($sformatf("enlo%0d.err", i),  32'(err), 0);
      check($sformatf("enlo%0d.lock", i), 32'(lock), 0);
      check($sformatf("enlo%0d.dir", i),  32'(dir), 0);
      check($sformatf("enlo%0d.level", i), 32'(level), 7);
      check($sformatf("enlo%0d.cycles", i), 32'(cycles), 1);
      check($sformatf("enlo%0d.code", i), 32'(err_code), 2);
    end
    en = 1'b1;
    wchk("enhi", 8'h0F, 4, 1'b1, 1'b0, 1'b0, 1'b0);

    // Hold level 5 in RISE
    wchk("st5", 8'h1F, 5, 1'b1, 1'b0, 1'b1, 1'b1);
    wchk("hold1", 8'h1F, 5, 1'b1, 1'b0, 1'b1, 1'b1);
    wchk("hold2", 8'h1F, 5, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef LBD_STALL_DET_EN
    exp_code = 3;
    wchk("hold3", 8'h1F, 5, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    wchk("hold3", 8'h1F, 5, 1'b1, 1'b0, 1'b1, 1'b1);
`endif

    // Further cycles up to counter saturation
    sweep(5, 15, 1, 1'b0);
    sweep(0, 15, 1, 1'b0);
    sweep(0, 15, 1, 1'b0);
    check("sat.cycles", 32'(cycles), 3);

    // Reset from a busy state
    rst = 1'b0;
    tick();
    check("rst2.level",  32'(level), 0);
    check("rst2.lock",   32'(lock), 0);
    check("rst2.dir",    32'(dir), 0);
    check("rst2.code",   32'(err_code), 0);
    check("rst2.cycles", 32'(cycles), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_bar_decoder.md
Name: led_bar_decoder

Overview:
- Receive-side companion to the 8-bit bar-graph LED animation generator.
- Watches the 8-bit bar pattern, including bits that flicker at the PWM/blink rate, and accumulates it over a fixed window.
- Decodes each window's thermometer code into a fill level 0..8 and tracks the fill/drain sequence.
- Reports the level, the direction, sequence errors and the count of completed animation cycles. Used as an on-chip monitor and as the checker in animation benches.

Parameters:
- WIN, 16, window length in clk cycles; must be ≥2.
- CNT_W, 16, width of the completed-cycle counter.
- STALL_WIN, 64, windows without a level change before a stall error; used only with LBD_STALL_DET_EN.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  decoder enable.
- bar_in  input  8  bar pattern under observation, bit0 = first LED to light.
- level  output  4  last decoded fill level, 0..8.
- level_vld  output  1  one-cycle pulse, new level decoded.
- dir  output  1  1 = filling (RISE), 0 = draining (FALL) or not locked.
- lock  output  1  FSM in RISE or FALL.
- err  output  1  one-cycle error pulse.
- err_code  output  2  01 = non-thermometer, 10 = sequence jump, 11 = stall; held until the next err.
- cycles  output  CNT_W  completed fill+drain cycles, saturating.

Behaviour:
- Reset (rst=0 at posedge):
  - level=0, level_vld=0, dir=0, lock=0, err=0, err_code=00, cycles=0.
  - Window counter wcnt=0, accumulator acc=0, FSM=IDLE.
- Window:
  - While en=1, each cycle: acc <= acc | bar_in; wcnt counts 0..WIN-1 and wraps.
  - On the cycle with wcnt==WIN-1: snap <= acc | bar_in, acc <= 0.
  - Any bit high at least once in the window counts as lit, so PWM flicker is absorbed.
- Decode latency: level_vld/err pulse on the cycle after the window-end cycle. One decode per WIN cycles.
- Thermometer check: snap must equal 2^k-1 for some k in 0..8, giving k = level.
  - Otherwise: err=1, err_code=01, level_vld=0, level and FSM state unchanged.
- FSM states:
  - IDLE: entered on en=0. Moves to ACQ on the first cycle en=1; the first window starts at wcnt=0.
  - ACQ: the first valid window records prev=k and pulses level_vld, with no sequence check. Then, per valid window:
    - k==8: go FALL.
    - k==0: go RISE.
    - k==prev+1: go RISE.
    - k==prev-1: go FALL.
    - k==prev: stay.
    - any other k: err, code 10, stay ACQ.
  - RISE:
    - k==prev: hold, no pulse error.
    - k==prev+1: accept.
    - k==8 (reached by +1): go FALL.
    - any other k: err, code 10, go ACQ with prev=k.
  - FALL:
    - k==prev: hold.
    - k==prev-1: accept.
    - k==0 (reached by -1): cycles++, go RISE.
    - any other k: err, code 10, go ACQ with prev=k.
- Every thermometer-valid window pulses level_vld and updates level, including windows flagged as jumps; in that case level_vld and err pulse together.
- dir=1 only in RISE; lock=1 in RISE or FALL.
- cycles saturates at 2^CNT_W-1 and never wraps.
- en low mid-window:
  - Next cycle: acc=0, wcnt=0, FSM=IDLE, lock=0, dir=0.
  - level, err_code and cycles hold. No pulses while en=0.
- rst low overrides en.

Optional Feature:
- Macro: LBD_STALL_DET_EN.
- Enabled:
  - A stall counter counts consecutive valid windows while in RISE/FALL with k==prev; it clears on any level change or on leaving RISE/FALL.
  - On reaching STALL_WIN: err=1, err_code=11, go ACQ, counter cleared.
- Disabled: no stall counter is built and code 11 never occurs.

Test Plan (WIN=4):
- Reset, then en=1, bar_in=8'h01 steady for 4 cycles -> level_vld on cycle 5 with level=1; lock=0, FSM=ACQ.
- Sweep 01,03,07,0F,1F,3F,7F,FF,7F,…,01,00,01, each held 8 cycles, with lit bits toggling every cycle -> level 1..8..0 with no err; dir=1 while rising, flips to 0 at level 8; cycles=1 on the 8→…→0 return.
- In RISE at level 3, present 8'h0B for one window -> err=1, err_code=01, level stays 3, lock stays 1.
- In RISE at level 3, jump to 8'h3F -> level_vld and err in the same cycle, level=6, err_code=10, lock=0 (ACQ).
- Drop en mid-window, then raise it -> no pulses while low, lock=0, cycles unchanged; re-acquires on the first full window after en returns.
- With LBD_STALL_DET_EN and STALL_WIN=3, hold level 5 in RISE -> err_code=11 on the third unchanged window, lock=0. Without the macro, no err.
